// File: rtl/des_pkg.sv
// Shared DES compression definitions: S-box tables, P permutation, FSM states.
// The DES_P_PERM_EN build option (see des_sbox_compress) uses P_TABLE.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Indexed [box][row][col]; box 0 is S1.
  localparam logic [3:0] SBOX [8][4][16] = '{
    '{'{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7},
      '{4'h0,4'hF,4'h7,4'h4,4'hE,4'h2,4'hD,4'h1,4'hA,4'h6,4'hC,4'hB,4'h9,4'h5,4'h3,4'h8},
      '{4'h4,4'h1,4'hE,4'h8,4'hD,4'h6,4'h2,4'hB,4'hF,4'hC,4'h9,4'h7,4'h3,4'hA,4'h5,4'h0},
      '{4'hF,4'hC,4'h8,4'h2,4'h4,4'h9,4'h1,4'h7,4'h5,4'hB,4'h3,4'hE,4'hA,4'h0,4'h6,4'hD}},
    '{'{4'hF,4'h1,4'h8,4'hE,4'h6,4'hB,4'h3,4'h4,4'h9,4'h7,4'h2,4'hD,4'hC,4'h0,4'h5,4'hA},
      '{4'h3,4'hD,4'h4,4'h7,4'hF,4'h2,4'h8,4'hE,4'hC,4'h0,4'h1,4'hA,4'h6,4'h9,4'hB,4'h5},
      '{4'h0,4'hE,4'h7,4'hB,4'hA,4'h4,4'hD,4'h1,4'h5,4'h8,4'hC,4'h6,4'h9,4'h3,4'h2,4'hF},
      '{4'hD,4'h8,4'hA,4'h1,4'h3,4'hF,4'h4,4'h2,4'hB,4'h6,4'h7,4'hC,4'h0,4'h5,4'hE,4'h9}},
    '{'{4'hA,4'h0,4'h9,4'hE,4'h6,4'h3,4'hF,4'h5,4'h1,4'hD,4'hC,4'h7,4'hB,4'h4,4'h2,4'h8},
      '{4'hD,4'h7,4'h0,4'h9,4'h3,4'h4,4'h6,4'hA,4'h2,4'h8,4'h5,4'hE,4'hC,4'hB,4'hF,4'h1},
      '{4'hD,4'h6,4'h4,4'h9,4'h8,4'hF,4'h3,4'h0,4'hB,4'h1,4'h2,4'hC,4'h5,4'hA,4'hE,4'h7},
      '{4'h1,4'hA,4'hD,4'h0,4'h6,4'h9,4'h8,4'h7,4'h4,4'hF,4'hE,4'h3,4'hB,4'h5,4'h2,4'hC}},
    '{'{4'h7,4'hD,4'hE,4'h3,4'h0,4'h6,4'h9,4'hA,4'h1,4'h2,4'h8,4'h5,4'hB,4'hC,4'h4,4'hF},
      '{4'hD,4'h8,4'hB,4'h5,4'h6,4'hF,4'h0,4'h3,4'h4,4'h7,4'h2,4'hC,4'h1,4'hA,4'hE,4'h9},
      '{4'hA,4'h6,4'h9,4'h0,4'hC,4'hB,4'h7,4'hD,4'hF,4'h1,4'h3,4'hE,4'h5,4'h2,4'h8,4'h4},
      '{4'h3,4'hF,4'h0,4'h6,4'hA,4'h1,4'hD,4'h8,4'h9,4'h4,4'h5,4'hB,4'hC,4'h7,4'h2,4'hE}},
    '{'{4'h2,4'hC,4'h4,4'h1,4'h7,4'hA,4'hB,4'h6,4'h8,4'h5,4'h3,4'hF,4'hD,4'h0,4'hE,4'h9},
      '{4'hE,4'hB,4'h2,4'hC,4'h4,4'h7,4'hD,4'h1,4'h5,4'h0,4'hF,4'hA,4'h3,4'h9,4'h8,4'h6},
      '{4'h4,4'h2,4'h1,4'hB,4'hA,4'hD,4'h7,4'h8,4'hF,4'h9,4'hC,4'h5,4'h6,4'h3,4'h0,4'hE},
      '{4'hB,4'h8,4'hC,4'h7,4'h1,4'hE,4'h2,4'hD,4'h6,4'hF,4'h0,4'h9,4'hA,4'h4,4'h5,4'h3}},
    '{'{4'hC,4'h1,4'hA,4'hF,4'h9,4'h2,4'h6,4'h8,4'h0,4'hD,4'h3,4'h4,4'hE,4'h7,4'h5,4'hB},
      '{4'hA,4'hF,4'h4,4'h2,4'h7,4'hC,4'h9,4'h5,4'h6,4'h1,4'hD,4'hE,4'h0,4'hB,4'h3,4'h8},
      '{4'h9,4'hE,4'hF,4'h5,4'h2,4'h8,4'hC,4'h3,4'h7,4'h0,4'h4,4'hA,4'h1,4'hD,4'hB,4'h6},
      '{4'h4,4'h3,4'h2,4'hC,4'h9,4'h5,4'hF,4'hA,4'hB,4'hE,4'h1,4'h7,4'h6,4'h0,4'h8,4'hD}},
    '{'{4'h4,4'hB,4'h2,4'hE,4'hF,4'h0,4'h8,4'hD,4'h3,4'hC,4'h9,4'h7,4'h5,4'hA,4'h6,4'h1},
      '{4'hD,4'h0,4'hB,4'h7,4'h4,4'h9,4'h1,4'hA,4'hE,4'h3,4'h5,4'hC,4'h2,4'hF,4'h8,4'h6},
      '{4'h1,4'h4,4'hB,4'hD,4'hC,4'h3,4'h7,4'hE,4'hA,4'hF,4'h6,4'h8,4'h0,4'h5,4'h9,4'h2},
      '{4'h6,4'hB,4'hD,4'h8,4'h1,4'h4,4'hA,4'h7,4'h9,4'h5,4'h0,4'hF,4'hE,4'h2,4'h3,4'hC}},
    '{'{4'hD,4'h2,4'h8,4'h4,4'h6,4'hF,4'hB,4'h1,4'hA,4'h9,4'h3,4'hE,4'h5,4'h0,4'hC,4'h7},
      '{4'h1,4'hF,4'hD,4'h8,4'hA,4'h3,4'h7,4'h4,4'hC,4'h5,4'h6,4'hB,4'h0,4'hE,4'h9,4'h2},
      '{4'h7,4'hB,4'h4,4'h1,4'h9,4'hC,4'hE,4'h2,4'h0,4'h6,4'hA,4'hD,4'hF,4'h3,4'h5,4'h8},
      '{4'h2,4'h1,4'hE,4'h7,4'h4,4'hA,4'h8,4'hD,4'hF,4'hC,4'h9,4'h0,4'h3,4'h5,4'h6,4'hB}}
  };

  // Output bit i (1-based, MSB first) takes input bit P_TABLE[i-1].
  localparam int unsigned P_TABLE [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  function automatic int unsigned cycles_for(input int unsigned sbox_per_cycle);
    return 8 / sbox_per_cycle;
  endfunction

endpackage

// File: rtl/des_sbox_compress_if.sv
// Valid/ready handshake bundle for the S-box compression stage.
interface des_sbox_compress_if;
  logic        valid_i;
  logic        ready_o;
  logic [1:48] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [1:32] data_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/des_sbox.sv
// Single DES S-box lookup; chunk bit 5 is DES b1, bit 0 is b6.
module des_sbox
  import des_pkg::*;
(
  input  logic [2:0] box_i,
  input  logic [5:0] chunk_i,
  output logic [3:0] sbox_o
);
  logic [1:0] row;
  logic [3:0] col;

  always_comb begin
    row    = {chunk_i[5], chunk_i[0]};
    col    = chunk_i[4:1];
    sbox_o = SBOX[box_i][row][col];
  end
endmodule

// File: rtl/des_sbox_compress.sv
// DES S-box compression 48 -> 32 bits, SBOX_PER_CYCLE boxes per clock.
// Define DES_P_PERM_EN to apply the DES P permutation to data_o.
module des_sbox_compress
  import des_pkg::*;
#(
  parameter int unsigned SBOX_PER_CYCLE = 1
) (
  input logic           clk_i,
  input logic           rst_ni,
  des_sbox_compress_if.slave bus
);
  if (!(SBOX_PER_CYCLE inside {1, 2, 4, 8})) begin : g_bad_param
    $error("des_sbox_compress: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam int unsigned CYCLES   = cycles_for(SBOX_PER_CYCLE);
  localparam logic [2:0]  LAST_CNT = 3'(CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:48] din_q, din_d;
  logic [1:32] res_q, res_d;
  logic        valid_q, valid_d;
  logic        ready;
  logic        accept;

  logic [5:0]  chunk_arr [8];
  logic [2:0]  box_idx   [SBOX_PER_CYCLE];
  logic [5:0]  chunk_sel [SBOX_PER_CYCLE];
  logic [3:0]  sbox_out  [SBOX_PER_CYCLE];

  always_comb begin
    ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ready_i);
    accept = bus.valid_i && ready;
  end

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) chunk_arr[k] = din_q[6*k+1 +: 6];
    for (int unsigned j = 0; j < SBOX_PER_CYCLE; j++) begin
      box_idx[j]   = 3'(32'(cnt_q) * SBOX_PER_CYCLE + j);
      chunk_sel[j] = chunk_arr[box_idx[j]];
    end
  end

  for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_sbox
    des_sbox u_sbox (
      .box_i  (box_idx[j]),
      .chunk_i(chunk_sel[j]),
      .sbox_o (sbox_out[j])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    res_d   = res_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          din_d   = bus.data_i;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Constant k keeps every result slot write a static part-select.
        for (int unsigned k = 0; k < 8; k++) begin
          for (int unsigned j = 0; j < SBOX_PER_CYCLE; j++) begin
            if (box_idx[j] == 3'(k)) res_d[4*k+1 +: 4] = sbox_out[j];
          end
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          if (bus.valid_i) begin
            din_d   = bus.data_i;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;

`ifdef DES_P_PERM_EN
  logic [1:32] perm;
  always_comb begin
    perm = '0;
    for (int unsigned i = 1; i <= 32; i++) perm[i] = res_q[P_TABLE[i-1]];
  end
  assign bus.data_o = perm;
`else
  assign bus.data_o = res_q;
`endif

endmodule

// File: doc/des_sbox_compress.md
Name: des_sbox_compress

Overview:
- Contracting counterpart of the DES E-expansion stage: takes a 48-bit round value (E(R) xor K) and compresses it to 32 bits through the eight DES S-boxes.
- Evaluates SBOX_PER_CYCLE S-boxes per clock for area/speed trade-off.
- Sits in the round datapath between the key-mix XOR and the round's L/R XOR, with valid/ready handshakes on both sides.

Parameters:
- SBOX_PER_CYCLE, 1, S-boxes evaluated per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.

Ports:
- clk_i  input  1  clock; rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  input word valid.
- ready_o  output  1  block can accept an input word.
- data_i  input  [1:48]  expanded, key-mixed word; bit 1 is MSB, DES numbering.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- data_o  output  [1:32]  S-box result; bit 1 is MSB.

Behaviour:
- Reset (async assert, sync-released by system): state=IDLE, ready_o=1, valid_o=0, data_o=0, internal chunk counter=0, input/result registers=0.
- Chunk k (1..8) is data_i[6k-5:6k], bits b1..b6.
  - row = {b1,b6}, col = b2..b5.
  - The 4-bit S-box output is written to result[4k-3:4k], MSB first.
- Input handshake: accept on valid_i && ready_o. On accept, data_i is captured; data_i may change afterwards.
- Output handshake:
  - valid_o and data_o are held stable until ready_i.
  - valid_o never drops without a handshake.
- FSM states:
  - IDLE: ready_o=1. On accept, capture data_i, counter=0, go to BUSY.
  - BUSY: ready_o=0. Each cycle evaluate chunks counter*N+1 .. counter*N+N (N=SBOX_PER_CYCLE), then increment counter. After 8/N cycles, go to DONE.
  - DONE: valid_o=1 and ready_o=ready_i.
    - ready_i && valid_i: output completes and the new word is captured in the same cycle; go to BUSY (back-to-back).
    - ready_i only: go to IDLE.
    - otherwise: stay in DONE.
- Latency: accept edge to valid_o high = 8/N cycles. Throughput: one word per 8/N cycles.
- N=8: BUSY lasts one cycle; latency is 1.
- valid_i while busy is ignored; upstream must hold it.
- rst_ni asserted mid-operation aborts the word immediately, with no partial output.
- Counter wrap: the counter is cleared on every accept and never wraps inside BUSY.

Optional Feature:
- Macro: DES_P_PERM_EN.
- Defined: data_o carries the DES P permutation of the S-box result (P table: 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25), applied combinationally on the result register. Latency is unchanged.
- Undefined: data_o is the raw S-box concatenation S1..S8.

Decomposition:
- des_pkg holds:
  - the eight S-box tables, as a constant array [8][4][16] of 4-bit values;
  - the P table;
  - the FSM state enum;
  - localparam CYCLES = 8/SBOX_PER_CYCLE.
- Sub-module des_sbox: purely combinational, inputs box index [2:0] and 6-bit chunk, output 4 bits. SBOX_PER_CYCLE instances are generated.

Test Plan:
- Zero vector: data_i=0x000000000000, macro off -> data_o=0xEFA72C4D after 8/N cycles.
- Known round value: data_i=0x6117BA866527.
  - Macro off -> data_o=0x5C82B597.
  - Macro on -> data_o=0x234AA9BB.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o -> data_o and valid_o stable, ready_o=0. Then ready_i=1 -> one transfer only.
- Back-to-back: valid_i held with two words and ready_i=1 -> both results correct, and the second accept occurs in the same cycle as the first output handshake.
- Reset mid-BUSY: assert rst_ni=0 two cycles after accept -> valid_o=0, ready_o=1, data_o=0 immediately. A subsequent word produces a correct result.
- Parameter sweep: repeat the first two scenarios for SBOX_PER_CYCLE=1,2,4,8 -> latencies 8,4,2,1 with identical data_o.
